// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and fetch state type
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'b0;
    localparam logic [31:0] PC_INC_DEFAULT  = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage feeding the IF/ID register
module if_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] IR_o,
    output logic [31:0] PC_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         buf_valid_q, buf_valid_d;
    logic         drop_q, drop_d;

    logic take, req, gnt_fire, resp, fill;

    assign take     = buf_valid_q && !stall_i;
    assign req      = (state_q == REQ) && (!buf_valid_q || take) && !rst_i;
    assign gnt_fire = req && imem_gnt_i;
    assign resp     = (state_q == WAIT) && imem_rvalid_i;
    assign fill     = resp && !drop_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        ir_d        = ir_q;
        pc_out_d    = pc_out_q;
        buf_valid_d = buf_valid_q;
        drop_d      = drop_q;

        if (redirect_i) begin
            pc_d        = redirect_pc_i & WORD_ALIGN_MASK;
            buf_valid_d = 1'b0;
            ir_d        = NOP_INSTR;
            pc_out_d    = 32'h0;
            // A response still in flight after this edge belongs to the old path.
            if (gnt_fire || ((state_q == WAIT) && !imem_rvalid_i)) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = REQ;
            end
        end else begin
            if (gnt_fire) begin
                state_d    = WAIT;
                req_addr_d = pc_q;
                pc_d       = pc_q + PC_INC;
            end
            if (resp) begin
                state_d = REQ;
                drop_d  = 1'b0;
            end
            if (fill) begin
                buf_valid_d = 1'b1;
                ir_d        = imem_rdata_i;
                pc_out_d    = req_addr_q + PC_INC;
            end else if (take) begin
                buf_valid_d = 1'b0;
                ir_d        = NOP_INSTR;
                pc_out_d    = 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= 32'h0;
            ir_q        <= NOP_INSTR;
            pc_out_q    <= 32'h0;
            buf_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            ir_q        <= ir_d;
            pc_out_q    <= pc_out_d;
            buf_valid_q <= buf_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign valid_o     = buf_valid_q;
    assign IR_o        = ir_q;
    assign PC_o        = pc_out_q;

    a_no_rvalid_in_req: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (state_q == REQ)));
    a_no_gnt_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_gnt_i && !req));

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipeline; the producer end of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Buffers the returned instruction and presents IR/PC to IF/ID.
- Honours hazard-unit stalls and branch/jump redirects; delivers a NOP (32'b0) when no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
PC_INC, 32'd4, PC increment per fetched instruction

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address; stable while imem_req_o=1
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  read data valid; at least 1 cycle after gnt
imem_rdata_i  in  32  instruction word
stall_i  in  1  consumer (IF/ID) not writing this cycle; inverse of IF/ID write enable
redirect_i  in  1  branch taken / jump; flush and restart fetch
redirect_pc_i  in  32  redirect target; bits[1:0] forced to 0
valid_o  out  1  IR_o/PC_o hold a real instruction
IR_o  out  32  instruction to IF/ID; 32'b0 when valid_o=0
PC_o  out  32  fetch address + PC_INC of IR_o; 0 when valid_o=0

Behaviour:
- Reset (async, immediate):
  - pc_q=RESET_PC, state=REQ, buf_valid=0, drop=0.
  - valid_o=0, IR_o=0, PC_o=0, imem_req_o=0.
- Take: buffered instruction consumed on a rising edge with valid_o=1 and stall_i=0.
- Output buffer: one entry. valid_o=buf_valid. IR_o/PC_o are registered and held unchanged while stalled.
- Request issue:
  - imem_req_o = (state==REQ) && (!buf_valid || take) && !rst_i.
  - imem_addr_o = pc_q.
  - At most one request outstanding.
- States:
  - REQ:
    - req&&gnt -> WAIT; req_addr_q<=pc_q; pc_q<=pc_q+PC_INC (32-bit wrap, no overflow flag).
    - Otherwise stay in REQ.
  - WAIT, on rvalid:
    - drop=1: discard data, clear drop -> REQ.
    - drop=0: buf<=rdata, buf_pc<=req_addr_q+PC_INC, buf_valid<=1 -> REQ.
  - WAIT without rvalid: stay.
- Buffer clear: on take with no simultaneous fill, buf_valid<=0 and IR_o/PC_o<=0.
- Redirect (highest priority, same edge):
  - pc_q<=redirect_pc_i & ~3.
  - buf_valid<=0, IR_o/PC_o<=0.
  - If a request is outstanding after this edge (state WAIT, or REQ with gnt this cycle): drop<=1 and state WAIT.
  - Otherwise state REQ.
  - Redirect overrides stall, take, fill and pc increment.
  - The new target is requested only after any stale response has been drained.
- Simultaneous events:
  - Take and fill on the same edge: buffer takes new data, valid_o stays 1.
  - rvalid while drop=1 and redirect: data dropped; drop stays 1 only if a new grant also occurred (cannot happen in WAIT, so drop<=0).
- Protocol errors (assert in sim, no recovery logic):
  - rvalid in REQ.
  - gnt without req.
- Reset mid-transaction:
  - State cleared; no drop tracking survives.
  - Memory must be reset by the same rst_i.
- Latency: redirect at edge N -> request for target visible after edge N (if nothing outstanding) -> instruction visible one cycle after rvalid.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR=32'b0, PC_INC default, WORD_ALIGN_MASK.
  - fetch_state_t enum {REQ, WAIT}.
  - Reusable by IF/ID, hazard unit and branch unit.
- No sub-module needed; the output buffer is inline.
- Target size is about 150 lines.

Test Plan:
- Zero-wait memory (gnt same cycle as req, rvalid 1 cycle later), no stall -> PC_o sequence 4, 8, 12 and IR_o equal to mem[0], mem[1], mem[2]; one instruction every 2 cycles.
- stall_i=1 for 5 cycles with buf_valid=1 -> IR_o/PC_o constant, imem_req_o=0; release -> next request at addr 4, 8, ....
- Redirect to 0x100 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on IR_o; next request addr=0x100; PC_o=0x104.
- Redirect and stall asserted together with buf_valid=1 -> next cycle valid_o=0, IR_o=0, PC_o=0; request to target issued.
- redirect_pc_i=0x0000_0103 -> imem_addr_o=0x100; pc_q at 0xFFFF_FFFC after grant -> wraps to 0.
- rst_i asserted mid-WAIT, asynchronously between edges -> outputs 0 immediately; after release first request addr=RESET_PC.
